// File: rtl/pong_pixel_renderer.sv
// Pong playfield renderer: ball, left paddle and background with 1-clock registered RGB/syncs.
// Optional 1-pixel white playfield border when PONG_BORDER_EN is defined.
module pong_pixel_renderer #(
  parameter int unsigned ResolutionSize = 10,
  parameter int unsigned ColorSize      = 4,
  parameter int unsigned BallSize       = 8,
  parameter int unsigned PaddleWidth    = 8,
  parameter int unsigned PaddleHeight   = 48,
  parameter int unsigned PaddleX        = 16,
  parameter int unsigned BallStep       = 2,
  parameter int unsigned PaddleStep     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ResolutionSize-1:0] Xresolution,
  input  logic [ResolutionSize-1:0] Yresolution,
  input  logic [ResolutionSize-1:0] xpos,
  input  logic [ResolutionSize-1:0] ypos,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      up,
  input  logic                      down,
  input  logic                      serve,
  output logic [ColorSize-1:0]      red,
  output logic [ColorSize-1:0]      green,
  output logic [ColorSize-1:0]      blue,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      miss,
  output logic [3:0]                score
);

  // One extra bit so edge sums never wrap.
  localparam int unsigned W = ResolutionSize + 1;
  typedef logic [W-1:0] wide_t;
  typedef logic [ResolutionSize-1:0] pos_t;

  localparam wide_t BallW   = wide_t'(BallSize);
  localparam wide_t PadXW   = wide_t'(PaddleX);
  localparam wide_t PadWW   = wide_t'(PaddleWidth);
  localparam wide_t PadHW   = wide_t'(PaddleHeight);
  localparam wide_t StepW   = wide_t'(BallStep);
  localparam wide_t PStepW  = wide_t'(PaddleStep);
  localparam logic [ColorSize-1:0] Ones = {ColorSize{1'b1}};

  typedef enum logic [1:0] {StIdle = 2'd0, StPlay = 2'd1, StMiss = 2'd2} state_e;

  state_e state_q;
  pos_t   ball_x_q, ball_y_q, paddle_y_q;
  logic   dx_q, dy_q;
  logic   vsync_prev_q;
  logic   tick;

  wide_t xw, yw, xres_w, yres_w, bx_w, by_w, py_w;
  assign xw     = {1'b0, xpos};
  assign yw     = {1'b0, ypos};
  assign xres_w = {1'b0, Xresolution};
  assign yres_w = {1'b0, Yresolution};
  assign bx_w   = {1'b0, ball_x_q};
  assign by_w   = {1'b0, ball_y_q};
  assign py_w   = {1'b0, paddle_y_q};

  assign tick = vsync_prev_q & ~vsync;

  // Pixel classification
  logic active, ball_hit, paddle_hit;
  logic [ColorSize-1:0] red_d, green_d, blue_d;
  assign active     = (xpos < Xresolution) && (ypos < Yresolution);
  assign ball_hit   = (xw >= bx_w) && (xw < bx_w + BallW) && (yw >= by_w) && (yw < by_w + BallW);
  assign paddle_hit = (xw >= PadXW) && (xw < PadXW + PadWW) &&
                      (yw >= py_w) && (yw < py_w + PadHW);

`ifdef PONG_BORDER_EN
  logic border;
  assign border = (xw == '0) || (xw == xres_w - wide_t'(1)) ||
                  (yw == '0) || (yw == yres_w - wide_t'(1));
`endif

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (active) begin
      if (ball_hit) begin
        red_d   = Ones;
        green_d = Ones;
        blue_d  = Ones;
      end else if (paddle_hit) begin
        green_d = Ones;
`ifdef PONG_BORDER_EN
      end else if (border) begin
        red_d   = Ones;
        green_d = Ones;
        blue_d  = Ones;
`endif
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      red          <= '0;
      green        <= '0;
      blue         <= '0;
      hsync        <= 1'b1;
      vsync        <= 1'b1;
      vsync_prev_q <= 1'b1;
    end else begin
      red          <= red_d;
      green        <= green_d;
      blue         <= blue_d;
      hsync        <= hsync_in;
      vsync        <= vsync_in;
      vsync_prev_q <= vsync;
    end
  end

  // Next-position decisions, all based on pre-move positions
  wide_t pad_max, pad_next, y_next, centre_x, centre_y;
  logic  dy_next, overlap, x_wall, x_pad, x_miss;

  assign pad_max  = yres_w - PadHW;
  assign centre_x = (xres_w - BallW) >> 1;
  assign centre_y = (yres_w - BallW) >> 1;
  assign overlap  = (by_w < py_w + PadHW) && (py_w < by_w + BallW);
  assign x_wall   = dx_q && (bx_w + BallW + StepW >= xres_w);
  assign x_pad    = !dx_q && (bx_w <= PadXW + PadWW + StepW) && overlap;
  assign x_miss   = !dx_q && (bx_w <= StepW) && !overlap;

  always_comb begin
    pad_next = py_w;
    if (up && !down) begin
      pad_next = (py_w <= PStepW) ? '0 : py_w - PStepW;
    end else if (down && !up) begin
      pad_next = (py_w + PStepW > pad_max) ? pad_max : py_w + PStepW;
    end
  end

  always_comb begin
    y_next  = dy_q ? by_w + StepW : by_w - StepW;
    dy_next = dy_q;
    if (!dy_q && (by_w <= StepW)) begin
      y_next  = '0;
      dy_next = 1'b1;
    end else if (dy_q && (by_w + BallW + StepW >= yres_w)) begin
      y_next  = yres_w - BallW;
      dy_next = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      ball_x_q   <= '0;
      ball_y_q   <= '0;
      paddle_y_q <= '0;
      dx_q       <= 1'b1;
      dy_q       <= 1'b1;
      miss       <= 1'b0;
      score      <= '0;
    end else begin
      miss <= 1'b0;
      if (tick) paddle_y_q <= pad_next[ResolutionSize-1:0];
      unique case (state_q)
        StIdle: begin
          ball_x_q <= centre_x[ResolutionSize-1:0];
          ball_y_q <= centre_y[ResolutionSize-1:0];
          if (tick && serve) begin
            state_q <= StPlay;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            score   <= '0;
          end
        end
        StPlay: begin
          if (tick) begin
            ball_y_q <= y_next[ResolutionSize-1:0];
            dy_q     <= dy_next;
            if (x_wall) begin
              dx_q     <= 1'b0;
              ball_x_q <= pos_t'(xres_w - BallW);
            end else if (x_pad) begin
              dx_q     <= 1'b1;
              ball_x_q <= pos_t'(PadXW + PadWW);
              if (score != 4'hf) score <= score + 4'd1;
            end else if (x_miss) begin
              ball_x_q <= '0;
              state_q  <= StMiss;
              miss     <= 1'b1;
            end else begin
              ball_x_q <= dx_q ? pos_t'(bx_w + StepW) : pos_t'(bx_w - StepW);
            end
          end
        end
        StMiss: begin
          if (tick) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_pixel_renderer.sv
// Directed bench for pong_pixel_renderer at 640x480: pixel path, serve, walls, paddle, miss, reset.
`timescale 1ns/1ps
module tb_pong_pixel_renderer;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] Xresolution, Yresolution, xpos, ypos;
  logic       hsync_in, vsync_in, up, down, serve;
  logic [3:0] red, green, blue, score;
  logic       hsync, vsync, miss;

  int checks = 0;
  int errors = 0;
  int m, msum;

  pong_pixel_renderer dut (
    .clock       (clock),
    .reset       (reset),
    .Xresolution (Xresolution),
    .Yresolution (Yresolution),
    .xpos        (xpos),
    .ypos        (ypos),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .up          (up),
    .down        (down),
    .serve       (serve),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .miss        (miss),
    .score       (score)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame: vsync_in low then high; counts clocks with miss high.
  task automatic frame(output int misses);
    misses = 0;
    vsync_in = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (miss) misses++;
    end
    vsync_in = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (miss) misses++;
    end
  endtask

  task automatic frames(input int n, output int misses);
    int t;
    misses = 0;
    for (int i = 0; i < n; i++) begin
      frame(t);
      misses += t;
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
    @(negedge clock);
    xpos = 10'(x);
    ypos = 10'(y);
    @(negedge clock);
    check_val(tag, {20'd0, red, green, blue}, {20'd0, exp});
  endtask

  task automatic chk_ball(input string tag, input int x, input int y);
    check_val({tag, ".x"}, 32'(dut.ball_x_q), x);
    check_val({tag, ".y"}, 32'(dut.ball_y_q), y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    Xresolution = 10'd640;
    Yresolution = 10'd480;
    xpos = '0;
    ypos = '0;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    up = 1'b0;
    down = 1'b0;
    serve = 1'b0;

    // Reset held with syncs low and a pixel that would hit a ball at (0,0)
    repeat (3) @(negedge clock);
    check_val("rst.rgb", {20'd0, red, green, blue}, 0);
    check_val("rst.hsync", hsync, 1);
    check_val("rst.vsync", vsync, 1);
    check_val("rst.score", score, 0);
    check_val("rst.miss", miss, 0);
    check_val("rst.state", 32'(dut.state_q), 0);
    check_val("rst.ball_x", 32'(dut.ball_x_q), 0);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk_ball("centre", 316, 236);

    // Pixel path
    pix("pix.ball", 316, 236, 12'hfff);
    pix("pix.ball_last", 323, 243, 12'hfff);
    pix("pix.ball_right", 324, 236, 12'h000);
    pix("pix.ball_below", 316, 244, 12'h000);
    pix("pix.inactive", 700, 236, 12'h000);
    pix("pix.paddle", 16, 0, 12'h0f0);
    pix("pix.paddle_right", 24, 0, 12'h000);
    pix("pix.paddle_bot", 16, 47, 12'h0f0);
    pix("pix.paddle_below", 16, 48, 12'h000);
    pix("pix.background", 100, 100, 12'h000);

    @(negedge clock);
    hsync_in = 1'b0;
    #1 check_val("hsync.before_edge", hsync, 1);
    @(negedge clock);
    check_val("hsync.after_edge", hsync, 0);
    hsync_in = 1'b1;
    @(negedge clock);
    check_val("hsync.rise", hsync, 1);

    // Paddle clamps at top, then moves down in IDLE
    up = 1'b1;
    frame(m);
    up = 1'b0;
    check_val("paddle.top_clamp", 32'(dut.paddle_y_q), 0);
    down = 1'b1;
    frames(50, m);
    down = 1'b0;
    check_val("paddle.down50", 32'(dut.paddle_y_q), 200);

    // Serve and first move
    serve = 1'b1;
    frame(m);
    serve = 1'b0;
    check_val("serve.state", 32'(dut.state_q), 1);
    check_val("serve.dx", dut.dx_q, 1);
    check_val("serve.dy", dut.dy_q, 1);
    chk_ball("serve", 316, 236);
    frame(m);
    chk_ball("move1", 318, 238);

    // Bottom wall
    frames(116, m);
    chk_ball("k117", 550, 470);
    check_val("k117.dy", dut.dy_q, 1);
    frame(m);
    check_val("bottom.y", 32'(dut.ball_y_q), 472);
    check_val("bottom.dy", dut.dy_q, 0);
    frame(m);
    check_val("bottom.next_y", 32'(dut.ball_y_q), 470);

    // Right wall at k=158, top wall at k=354
    frames(39, m);
    chk_ball("right_wall", 632, 392);
    check_val("right_wall.dx", dut.dx_q, 0);
    frames(196, m);
    chk_ball("top_wall", 240, 0);
    check_val("top_wall.dy", dut.dy_q, 1);

    // Paddle hit at k=462
    frames(107, m);
    chk_ball("pre_hit", 26, 214);
    check_val("pre_hit.score", score, 0);
    frame(m);
    chk_ball("hit", 24, 216);
    check_val("hit.dx", dut.dx_q, 1);
    check_val("hit.score", score, 1);

    // Narrow playfield bounces the ball straight back for 20 more hits
    Xresolution = 10'd32;
    for (int i = 1; i <= 20; i++) begin
      down = 1'b1;
      frame(m);
      down = 1'b0;
      frame(m);
      check_val($sformatf("hits.score%0d", i), score, (i + 1 > 15) ? 15 : i + 1);
    end
    chk_ball("hits.end", 24, 296);
    check_val("hits.paddle", 32'(dut.paddle_y_q), 280);

    // Move paddle away, turn ball around, let it pass
    Xresolution = 10'd640;
    up = 1'b1;
    frames(20, msum);
    up = 1'b0;
    check_val("away.paddle", 32'(dut.paddle_y_q), 200);
    chk_ball("away", 64, 336);
    Xresolution = 10'd72;
    frame(m);
    Xresolution = 10'd640;
    check_val("turn.dx", dut.dx_q, 0);
    chk_ball("turn", 64, 338);
    frames(31, m);
    check_val("approach.misses", msum + m, 0);
    check_val("approach.x", 32'(dut.ball_x_q), 2);
    frame(m);
    check_val("miss.pulses", m, 1);
    check_val("miss.state", 32'(dut.state_q), 2);
    check_val("miss.x", 32'(dut.ball_x_q), 0);

    // MISS -> IDLE; serve ignored here; both buttons hold paddle
    up = 1'b1;
    down = 1'b1;
    serve = 1'b1;
    frame(m);
    up = 1'b0;
    down = 1'b0;
    check_val("idle.state", 32'(dut.state_q), 0);
    chk_ball("idle", 316, 236);
    check_val("idle.paddle", 32'(dut.paddle_y_q), 200);
    check_val("idle.score", score, 15);
    frame(m);
    serve = 1'b0;
    check_val("reserve.state", 32'(dut.state_q), 1);
    check_val("reserve.score", score, 0);
    frames(3, m);
    chk_ball("rally2", 322, 242);

    // Asynchronous reset mid-rally
    @(negedge clock);
    xpos = 10'd322;
    ypos = 10'd242;
    @(negedge clock);
    check_val("pre_rst.rgb", {20'd0, red, green, blue}, 32'hfff);
    #2 reset = 1'b1;
    #1;
    check_val("async_rst.rgb", {20'd0, red, green, blue}, 0);
    check_val("async_rst.state", 32'(dut.state_q), 0);
    check_val("async_rst.ball_x", 32'(dut.ball_x_q), 0);
    check_val("async_rst.paddle", 32'(dut.paddle_y_q), 0);
    check_val("async_rst.dx", dut.dx_q, 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_pixel_renderer.md
Name: pong_pixel_renderer

Overview:
- Sits directly downstream of the CRT timing controller and consumes its hsync, vsync, xpos and ypos.
- Draws one Pong playfield: a ball, a left player paddle and a black background, and emits registered RGB with syncs re-aligned to the pixels.
- Runs a serve/play/miss state machine and advances game objects once per frame, on the vsync falling edge.

Parameters:
ResolutionSize, 10, width of xpos/ypos/resolution buses
ColorSize, 4, bits per colour channel
BallSize, 8, ball edge length in pixels (square)
PaddleWidth, 8, paddle width in pixels
PaddleHeight, 48, paddle height in pixels
PaddleX, 16, paddle left edge x coordinate
BallStep, 2, ball move per frame per axis
PaddleStep, 4, paddle move per frame

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
Xresolution  in  ResolutionSize  active video width
Yresolution  in  ResolutionSize  active video height
xpos  in  ResolutionSize  current x from CRT controller
ypos  in  ResolutionSize  current y from CRT controller
hsync_in  in  1  active-low hsync from CRT controller
vsync_in  in  1  active-low vsync from CRT controller
up  in  1  paddle up request (level)
down  in  1  paddle down request (level)
serve  in  1  start rally (level)
red  out  ColorSize  pixel red
green  out  ColorSize  pixel green
blue  out  ColorSize  pixel blue
hsync  out  1  hsync_in delayed 1 clock
vsync  out  1  vsync_in delayed 1 clock
miss  out  1  one-clock pulse when ball passes paddle
score  out  4  paddle hits this rally, saturating at 15

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high and may assert mid-frame or mid-rally; everything returns to reset values immediately.
- Reset values: red/green/blue=0, hsync=1, vsync=1, miss=0, score=0, state=IDLE, ballX=ballY=0, paddleY=0, dx=1, dy=1.
- Frame tick: internal one-clock pulse when registered vsync_in goes 1->0. All game state except IDLE centring updates only on a frame tick.
- Pixel path, 1-clock latency:
  - active = (xpos < Xresolution) && (ypos < Yresolution).
  - Ball hit: xpos in [ballX, ballX+BallSize) and ypos in [ballY, ballY+BallSize).
  - Paddle hit: xpos in [PaddleX, PaddleX+PaddleWidth) and ypos in [paddleY, paddleY+PaddleHeight).
  - Colour priority: inactive -> all 0; ball -> all channels all-ones; paddle -> green all-ones only; else 0.
  - hsync/vsync are registered in the same clock so they stay aligned with RGB.
- Paddle, updated on tick in every state:
  - up&&!down: paddleY = max(paddleY-PaddleStep, 0).
  - down&&!up: paddleY = min(paddleY+PaddleStep, Yresolution-PaddleHeight).
  - Both or neither: hold.
- IDLE:
  - Every clock: ballX=(Xresolution-BallSize)>>1, ballY=(Yresolution-BallSize)>>1.
  - On tick with serve=1: go to PLAY, dx=1 (right), dy=1 (down), score=0.
- PLAY, on tick; next-position tests use ball position before the move:
  - y axis:
    - dy=0 and ballY<=BallStep: set dy=1, ballY=0.
    - dy=1 and ballY+BallSize+BallStep>=Yresolution: set dy=0, ballY=Yresolution-BallSize.
    - Otherwise ballY += or -= BallStep.
  - x axis, right wall: dx=1 and ballX+BallSize+BallStep>=Xresolution: set dx=0, ballX=Xresolution-BallSize.
  - x axis, paddle: dx=0 and ballX<=PaddleX+PaddleWidth+BallStep and the ball's y span overlaps the paddle's y span (pre-move values).
    - Set dx=1 and ballX=PaddleX+PaddleWidth.
    - score=score+1, saturating at 15.
  - x axis, left miss: dx=0 and ballX<=BallStep with no paddle overlap: ballX=0, go to MISS, miss=1 for exactly one clock.
  - Otherwise ballX += or -= BallStep.
  - A corner reflects both axes on the same tick.
  - The paddle check takes precedence over the miss check.
- MISS: ball frozen at its last position, still drawn. On the next tick go to IDLE. Score holds until the next serve.
- serve is ignored outside IDLE.

Optional Feature:
- Macro PONG_BORDER_EN.
- Defined: a 1-pixel white border is drawn on active pixels with x==0, x==Xresolution-1, y==0 or y==Yresolution-1. Priority: below ball and paddle, above background.
- Undefined: no border logic; background is black everywhere.

Test Plan:
- Reset: assert reset mid-frame -> RGB=0, hsync=vsync=1, score=0, miss=0; after release with Xres=640, Yres=480, ball centred at (316,236) within 1 clock.
- Pixel latency: xpos=316, ypos=236 in IDLE -> RGB all-ones 1 clock later; xpos=700 -> RGB=0; hsync_in toggle appears on hsync exactly 1 clock later.
- Serve and motion: serve=1, one vsync_in falling edge -> PLAY; next tick ballX 316->318, ballY 236->238.
- Bottom wall: force ballY=470, dy=1, tick -> ballY=472, dy=0; following tick ballY=470.
- Paddle hit: ballX=26, dx=0, ballY=100, paddleY=90, tick -> dx=1, ballX=24, score=1. Repeat 20 hits -> score stays at 15.
- Miss: ballX=2, dx=0, paddleY=300, ballY=50, tick -> miss high for 1 clock, MISS; next tick -> IDLE and ball re-centred; up and down held together -> paddleY unchanged.
